axis_pkt_sink: RTL and testbench



---
 rtl/axis_pkt_sink.sv | 159 +++++++++++++++
 tb/tb_axis_pkt_sink.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_sink.sv
// AXI-Stream packet sink: pseudo-random TREADY backpressure, per-packet length/beats/checksum,
// cumulative packet/byte statistics and sticky TKEEP legality flags.
module axis_pkt_sink #(
    parameter int          C_TDATA_WIDTH = 32,
    parameter logic [15:0] C_LFSR_SEED   = 16'hACE1,
    parameter int          C_STAT_WIDTH  = 32
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic                       S_AXIS_TVALID,
    input  logic [C_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
    input  logic                       S_AXIS_TLAST,
    output logic                       S_AXIS_TREADY,
    input  logic                       BP_EN,
    input  logic [7:0]                 BP_THRESH,
    input  logic                       CLR_STATS,
    output logic                       PKT_DONE,
    output logic [15:0]                PKT_LEN,
    output logic [15:0]                PKT_BEATS,
    output logic [C_TDATA_WIDTH-1:0]   PKT_CSUM,
    output logic [C_STAT_WIDTH-1:0]    PKT_COUNT,
    output logic [C_STAT_WIDTH-1:0]    BYTE_COUNT,
    output logic [2:0]                 ERR
);

    localparam int          KW        = C_TDATA_WIDTH / 8;
    localparam logic [15:0] LFSR_INIT = (C_LFSR_SEED == 16'h0000) ? 16'h0001 : C_LFSR_SEED;

    typedef enum logic {IDLE, BODY} state_t;

    state_t                     r_state, w_state_nxt;
    logic [15:0]                r_lfsr;
    logic                       w_lfsr_fb;
    logic                       w_accept;
    logic                       w_first;
    logic [7:0]                 w_bytes;
    logic [C_TDATA_WIDTH-1:0]   w_mdata;
    logic [KW-1:0]              w_keep_p1;
    logic [2:0]                 w_err;
    logic [16:0]                w_len_sum;
    logic [16:0]                w_beats_sum;
    logic [15:0]                w_len_nxt;
    logic [15:0]                w_beats_nxt;
    logic [C_TDATA_WIDTH-1:0]   w_csum_nxt;

    logic [15:0]                r_len;
    logic [15:0]                r_beats;
    logic [C_TDATA_WIDTH-1:0]   r_csum;
    logic                       r_done;
    logic [15:0]                r_pkt_len;
    logic [15:0]                r_pkt_beats;
    logic [C_TDATA_WIDTH-1:0]   r_pkt_csum;
    logic [C_STAT_WIDTH-1:0]    r_pkt_count;
    logic [C_STAT_WIDTH-1:0]    r_byte_count;
    logic [2:0]                 r_err;

    // Fibonacci x^16+x^14+x^13+x^11+1 in right-shift form (taps at bits 0,2,3,5)
    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            r_lfsr <= LFSR_INIT;
        else if (BP_EN)
            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end

    // Ready never looks at TVALID, so the source can't form a combinational loop through us
    assign S_AXIS_TREADY = ARESETN & (~BP_EN | (r_lfsr[7:0] >= BP_THRESH));
    assign w_accept      = S_AXIS_TVALID & S_AXIS_TREADY;
    assign w_first       = (r_state == IDLE);

    always_comb begin
        w_bytes = 8'd0;
        w_mdata = '0;
        for (int i = 0; i < KW; i++) begin
            w_bytes            = w_bytes + 8'(S_AXIS_TKEEP[i]);
            w_mdata[8*i +: 8]  = S_AXIS_TKEEP[i] ? S_AXIS_TDATA[8*i +: 8] : 8'h00;
        end
    end

    assign w_keep_p1 = S_AXIS_TKEEP + KW'(1);
    assign w_err[0]  = (S_AXIS_TKEEP != '0) && ((S_AXIS_TKEEP & w_keep_p1) != '0);
    assign w_err[1]  = (S_AXIS_TKEEP == '0);
    assign w_err[2]  = !S_AXIS_TLAST && (S_AXIS_TKEEP != '1);

    assign w_len_sum   = {1'b0, r_len} + 17'(w_bytes);
    assign w_beats_sum = {1'b0, r_beats} + 17'd1;
    assign w_len_nxt   = w_first ? 16'(w_bytes) : (w_len_sum[16] ? 16'hFFFF : w_len_sum[15:0]);
    assign w_beats_nxt = w_first ? 16'd1 : (w_beats_sum[16] ? 16'hFFFF : w_beats_sum[15:0]);
    assign w_csum_nxt  = w_first ? w_mdata : (r_csum ^ w_mdata);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && !S_AXIS_TLAST) w_state_nxt = BODY;
            BODY:    if (w_accept &&  S_AXIS_TLAST) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_len       <= '0;
            r_beats     <= '0;
            r_csum      <= '0;
            r_done      <= 1'b0;
            r_pkt_len   <= '0;
            r_pkt_beats <= '0;
            r_pkt_csum  <= '0;
        end else begin
            r_done <= w_accept & S_AXIS_TLAST;
            if (w_accept) begin
                r_len   <= w_len_nxt;
                r_beats <= w_beats_nxt;
                r_csum  <= w_csum_nxt;
                if (S_AXIS_TLAST) begin
                    r_pkt_len   <= w_len_nxt;
                    r_pkt_beats <= w_beats_nxt;
                    r_pkt_csum  <= w_csum_nxt;
                end
            end
        end
    end

    // Clear wins over same-cycle increments and error sets
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_pkt_count  <= '0;
            r_byte_count <= '0;
            r_err        <= '0;
        end else if (CLR_STATS) begin
            r_pkt_count  <= '0;
            r_byte_count <= '0;
            r_err        <= '0;
        end else if (w_accept) begin
            r_byte_count <= r_byte_count + C_STAT_WIDTH'(w_bytes);
            r_err        <= r_err | w_err;
            if (S_AXIS_TLAST)
                r_pkt_count <= r_pkt_count + C_STAT_WIDTH'(1);
        end
    end

    assign PKT_DONE   = r_done;
    assign PKT_LEN    = r_pkt_len;
    assign PKT_BEATS  = r_pkt_beats;
    assign PKT_CSUM   = r_pkt_csum;
    assign PKT_COUNT  = r_pkt_count;
    assign BYTE_COUNT = r_byte_count;
    assign ERR        = r_err;

endmodule

// File: tb/tb_axis_pkt_sink.sv
// Directed bench for axis_pkt_sink: hand-computed expectations plus a reference LFSR for backpressure.
module tb_axis_pkt_sink;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        S_AXIS_TVALID;
    logic [31:0] S_AXIS_TDATA;
    logic [3:0]  S_AXIS_TKEEP;
    logic        S_AXIS_TLAST;
    logic        S_AXIS_TREADY;
    logic        BP_EN;
    logic [7:0]  BP_THRESH;
    logic        CLR_STATS;
    logic        PKT_DONE;
    logic [15:0] PKT_LEN;
    logic [15:0] PKT_BEATS;
    logic [31:0] PKT_CSUM;
    logic [31:0] PKT_COUNT;
    logic [31:0] BYTE_COUNT;
    logic [2:0]  ERR;

    int total = 0;
    int bad   = 0;

    always #5 ACLK = ~ACLK;

    axis_pkt_sink dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TKEEP  (S_AXIS_TKEEP),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .BP_EN         (BP_EN),
        .BP_THRESH     (BP_THRESH),
        .CLR_STATS     (CLR_STATS),
        .PKT_DONE      (PKT_DONE),
        .PKT_LEN       (PKT_LEN),
        .PKT_BEATS     (PKT_BEATS),
        .PKT_CSUM      (PKT_CSUM),
        .PKT_COUNT     (PKT_COUNT),
        .BYTE_COUNT    (BYTE_COUNT),
        .ERR           (ERR)
    );

    // Reference: x^16+x^14+x^13+x^11+1, the classic right-shifting 0xACE1 generator
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    // One beat handshake; the beat is accepted at the edge following a cycle with TREADY=1
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic clr);
        int n;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = d;
        S_AXIS_TKEEP  = k;
        S_AXIS_TLAST  = l;
        n = 0;
        while (S_AXIS_TREADY !== 1'b1 && n < 1000) begin
            tick;
            n++;
        end
        if (n >= 1000) chk("send_timeout", S_AXIS_TREADY, 1);
        CLR_STATS = clr;
        tick;
        CLR_STATS     = 1'b0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic clr_pulse;
        CLR_STATS = 1'b1;
        tick;
        CLR_STATS = 1'b0;
    endtask

    initial begin
        logic [15:0] m_lfsr;
        int          acc;
        int          cyc;

        ARESETN       = 1'b0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TKEEP  = '0;
        S_AXIS_TLAST  = 1'b0;
        BP_EN         = 1'b0;
        BP_THRESH     = 8'h00;
        CLR_STATS     = 1'b0;

        // Reset state
        tick;
        tick;
        chk("rst_done",   PKT_DONE, 0);
        chk("rst_len",    PKT_LEN, 0);
        chk("rst_beats",  PKT_BEATS, 0);
        chk("rst_csum",   PKT_CSUM, 0);
        chk("rst_count",  PKT_COUNT, 0);
        chk("rst_bytes",  BYTE_COUNT, 0);
        chk("rst_err",    ERR, 0);
        chk("rst_tready", S_AXIS_TREADY, 0);
        ARESETN = 1'b1;
        #1;
        chk("nobp_tready", S_AXIS_TREADY, 1);

        // 3-beat packet, no backpressure
        send(32'h11223344, 4'hF, 1'b0, 1'b0);
        chk("t1_done_mid", PKT_DONE, 0);
        send(32'h55667788, 4'hF, 1'b0, 1'b0);
        chk("t1_tready", S_AXIS_TREADY, 1);
        send(32'h0000AABB, 4'h3, 1'b1, 1'b0);
        chk("t1_done",  PKT_DONE, 1);
        chk("t1_len",   PKT_LEN, 10);
        chk("t1_beats", PKT_BEATS, 3);
        chk("t1_csum",  PKT_CSUM, 32'h4444EE77);
        chk("t1_count", PKT_COUNT, 1);
        chk("t1_bytes", BYTE_COUNT, 10);
        chk("t1_err",   ERR, 0);
        tick;
        chk("t1_done_pulse", PKT_DONE, 0);
        chk("t1_len_hold",   PKT_LEN, 10);

        // Random backpressure against the reference LFSR, TVALID held high
        clr_pulse;
        chk("t2_clr_count", PKT_COUNT, 0);
        BP_THRESH     = 8'h80;
        BP_EN         = 1'b1;
        m_lfsr        = 16'hACE1;
        acc           = 0;
        cyc           = 0;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TKEEP  = 4'hF;
        S_AXIS_TLAST  = 1'b1;
        while (acc < 100 && cyc < 2000) begin
            S_AXIS_TDATA = 32'(cyc);
            chk("t2_tready", S_AXIS_TREADY, (m_lfsr[7:0] >= 8'h80) ? 1 : 0);
            if (m_lfsr[7:0] >= 8'h80) acc++;
            tick;
            m_lfsr = lfsr_next(m_lfsr);
            chk("t2_count_track", PKT_COUNT, acc);
            cyc++;
        end
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        BP_EN         = 1'b0;
        chk("t2_count", PKT_COUNT, 100);
        chk("t2_bytes", BYTE_COUNT, 400);

        // Sticky TKEEP error flags
        send(32'hAABBCCDD, 4'h5, 1'b1, 1'b0);
        chk("t3_err_a",  ERR, 3'b001);
        chk("t3_len_a",  PKT_LEN, 2);
        chk("t3_csum_a", PKT_CSUM, 32'h00BB00DD);
        send(32'h12345678, 4'h0, 1'b1, 1'b0);
        chk("t3_err_b",  ERR, 3'b011);
        chk("t3_len_b",  PKT_LEN, 0);
        send(32'h01020304, 4'h7, 1'b0, 1'b0);
        chk("t3_err_c",  ERR, 3'b111);
        send(32'h00000000, 4'hF, 1'b1, 1'b0);
        chk("t3_err_sticky", ERR, 3'b111);
        chk("t3_beats_d",    PKT_BEATS, 2);
        chk("t3_len_d",      PKT_LEN, 7);
        clr_pulse;
        chk("t3_clr_err",   ERR, 0);
        chk("t3_clr_count", PKT_COUNT, 0);
        chk("t3_clr_bytes", BYTE_COUNT, 0);
        chk("t3_clr_len",   PKT_LEN, 7);

        // Clear coinciding with a TLAST acceptance
        send(32'h00000001, 4'hF, 1'b0, 1'b0);
        chk("t4_bytes_mid", BYTE_COUNT, 4);
        send(32'h00000002, 4'hF, 1'b1, 1'b1);
        chk("t4_done",  PKT_DONE, 1);
        chk("t4_len",   PKT_LEN, 8);
        chk("t4_beats", PKT_BEATS, 2);
        chk("t4_csum",  PKT_CSUM, 3);
        chk("t4_count", PKT_COUNT, 0);
        chk("t4_bytes", BYTE_COUNT, 0);

        // Reset in the middle of a packet
        send(32'h0000000A, 4'hF, 1'b0, 1'b0);
        send(32'h0000000B, 4'hF, 1'b0, 1'b0);
        ARESETN = 1'b0;
        #1;
        chk("t5_tready_rst0", S_AXIS_TREADY, 0);
        tick;
        chk("t5_tready_rst1", S_AXIS_TREADY, 0);
        chk("t5_done_rst",    PKT_DONE, 0);
        chk("t5_bytes_rst",   BYTE_COUNT, 0);
        tick;
        ARESETN = 1'b1;
        tick;
        chk("t5_no_done", PKT_DONE, 0);
        send(32'h1234ABCD, 4'h3, 1'b1, 1'b0);
        chk("t5_done",  PKT_DONE, 1);
        chk("t5_len",   PKT_LEN, 2);
        chk("t5_beats", PKT_BEATS, 1);
        chk("t5_csum",  PKT_CSUM, 32'h0000ABCD);
        chk("t5_count", PKT_COUNT, 1);

        // Threshold 0 keeps TREADY high; 70000-beat packet saturates length and beats
        clr_pulse;
        BP_THRESH     = 8'h00;
        BP_EN         = 1'b1;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TKEEP  = 4'hF;
        for (int i = 0; i < 70000; i++) begin
            S_AXIS_TDATA = 32'(i);
            S_AXIS_TLAST = (i == 69999);
            chk("t6_tready", S_AXIS_TREADY, 1);
            tick;
        end
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        chk("t6_done",  PKT_DONE, 1);
        chk("t6_beats", PKT_BEATS, 16'hFFFF);
        chk("t6_len",   PKT_LEN, 16'hFFFF);
        chk("t6_bytes", BYTE_COUNT, 280000);
        chk("t6_count", PKT_COUNT, 1);
        chk("t6_err",   ERR, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
